// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - round-robin arbiter sharing one data-memory port between two requesters
//
// Requester 0 (CPU data bus) and requester 1 (loader/DMA) each present REQ/RW/A/WD
// and receive GNT (ISSUE..RESP), a one-cycle ACK and RD. Memory side is MEN/MWE/MA/MWD
// out and MRD in, with MRD valid MEM_LAT cycles after the edge that samples MEN=1.
// BUSY is high whenever the arbiter is not idle. RW=1 means read.

module dmem_arb #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          R0_REQ,
    input  logic          R0_RW,
    input  logic [AW-1:0] R0_A,
    input  logic [DW-1:0] R0_WD,
    output logic          R0_GNT,
    output logic          R0_ACK,
    output logic [DW-1:0] R0_RD,
    input  logic          R1_REQ,
    input  logic          R1_RW,
    input  logic [AW-1:0] R1_A,
    input  logic [DW-1:0] R1_WD,
    output logic          R1_GNT,
    output logic          R1_ACK,
    output logic [DW-1:0] R1_RD,
    output logic          MEN,
    output logic          MWE,
    output logic [AW-1:0] MA,
    output logic [DW-1:0] MWD,
    input  logic [DW-1:0] MRD,
    output logic          BUSY
);

    localparam int CW = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            rw_q, rw_d;
    logic [AW-1:0]   a_q, a_d;
    logic [DW-1:0]   wd_q, wd_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            men_q, men_d;
    logic            mwe_q, mwe_d;
    logic [AW-1:0]   ma_q, ma_d;
    logic [DW-1:0]   mwd_q, mwd_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      ack_q, ack_d;
    logic            busy_q, busy_d;
    logic [DW-1:0]   rd0_q, rd0_d;
    logic [DW-1:0]   rd1_q, rd1_d;

    logic            take;
    logic            pick;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rw_d    = rw_q;
        a_d     = a_q;
        wd_d    = wd_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        men_d   = 1'b0;
        mwe_d   = 1'b0;
        ma_d    = '0;
        mwd_d   = '0;
        gnt_d   = 2'b00;
        ack_d   = 2'b00;
        busy_d  = 1'b0;
        take    = 1'b0;
        pick    = owner_q;

        case (state_q)
            S_IDLE: begin
                if (R0_REQ && R1_REQ) begin
                    take = 1'b1;
                    pick = ~last_q;
                end else if (R0_REQ) begin
                    take = 1'b1;
                    pick = 1'b0;
                end else if (R1_REQ) begin
                    take = 1'b1;
                    pick = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = (MEM_LAT > 1) ? S_WAIT : S_RESP;
                cnt_d   = CW'(MEM_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                last_d = owner_q;
                if (rw_q) begin
                    if (owner_q) rd1_d = MRD;
                    else         rd0_d = MRD;
                end
                // The owner's own REQ is still high here by protocol, so only the
                // other requester can chain straight into a new ISSUE.
                if (owner_q ? R0_REQ : R1_REQ) begin
                    take = 1'b1;
                    pick = ~owner_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (take) begin
            state_d = S_ISSUE;
            owner_d = pick;
            rw_d    = pick ? R1_RW : R0_RW;
            a_d     = pick ? R1_A  : R0_A;
            wd_d    = pick ? R1_WD : R0_WD;
        end

        // Outputs are registered: decode them from the state being entered.
        busy_d = (state_d != S_IDLE);
        if (state_d != S_IDLE) gnt_d[owner_d] = 1'b1;
        if (state_d == S_ISSUE) begin
            men_d = 1'b1;
            mwe_d = ~rw_d;
            ma_d  = a_d;
            mwd_d = wd_d;
        end
        if (state_d == S_RESP) ack_d[owner_d] = 1'b1;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rw_q    <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            men_q   <= 1'b0;
            mwe_q   <= 1'b0;
            ma_q    <= '0;
            mwd_q   <= '0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            busy_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rw_q    <= rw_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            men_q   <= men_d;
            mwe_q   <= mwe_d;
            ma_q    <= ma_d;
            mwd_q   <= mwd_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    assign MEN    = men_q;
    assign MWE    = mwe_q;
    assign MA     = ma_q;
    assign MWD    = mwd_q;
    assign BUSY   = busy_q;
    assign R0_GNT = gnt_q[0];
    assign R1_GNT = gnt_q[1];
    assign R0_ACK = ack_q[0];
    assign R1_ACK = ack_q[1];

    // MRD only becomes valid in RESP, so during the ACK cycle of a read the data is
    // forwarded straight through; the captured copy is held from then on.
    assign R0_RD = (ack_q[0] && rw_q) ? MRD : rd0_q;
    assign R1_RD = (ack_q[1] && rw_q) ? MRD : rd1_q;

endmodule
